// File: rtl/usr_sequencer.sv
// ---------------------------------------------------------------------------
// usr_sequencer
//
// Command sequencer for one Universal_Shift_Register instance. A host hands
// over load / shift / rotate commands through a valid/ready handshake; the
// sequencer parallel-loads the word, steps the register the requested number
// of times, then offers the resulting register word on a response handshake.
//
// Parameters
//   WIDTH      shift-register width (must match the controlled register)
//   CW         width of the shift-count field
//
// Ports
//   clk         rising-edge clock, shared with the shift register
//   clear       asynchronous active-low reset
//   cmd_valid   command offered
//   cmd_ready   sequencer can accept a command (high only in IDLE)
//   cmd_op      000 load, 001 shr, 010 shl, 011 ror, 100 rol, others load
//   cmd_data    word parallel-loaded before stepping
//   cmd_count   number of steps, 0 allowed, no clamping
//   cmd_fill    serial fill bit for shift ops
//   rsp_valid   result available
//   rsp_ready   result consumer ready
//   rsp_data    result word, forced to 0 while rsp_valid is low
//   busy        high in every state except IDLE
//   usr_s       register mode: 00 hold, 01 shr, 10 shl, 11 load
//   usr_p_in    register parallel input
//   usr_msb_in  register serial input entering the MSB on shift right
//   usr_lsb_in  register serial input entering the LSB on shift left
//   usr_q       register parallel output
//
// Build option
//   USR_SEQ_ROTATE_EN  when defined, ops 011/100 rotate by feeding the end bit
//                      of usr_q back into the serial input. When undefined,
//                      they act as plain shifts using cmd_fill and no path
//                      from usr_q to the serial inputs exists.
// ---------------------------------------------------------------------------
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CW-1:0]    cmd_count,
    input  logic             cmd_fill,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [1:0]       usr_s,
    output logic [WIDTH-1:0] usr_p_in,
    output logic             usr_msb_in,
    output logic             usr_lsb_in,
    input  logic [WIDTH-1:0] usr_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t            state_q, state_d;
    logic              shift_op_q, shift_op_d;
    logic              left_q, left_d;
    logic [CW-1:0]     count_q, count_d;
    logic              fill_q, fill_d;
    logic [1:0]        usr_s_q, usr_s_d;
    logic [WIDTH-1:0]  usr_p_in_q, usr_p_in_d;
    logic              msb_q, msb_d;
    logic              lsb_q, lsb_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
`ifdef USR_SEQ_ROTATE_EN
    logic              rot_q, rot_d;
    logic              rot_active;
`endif

    // Next-state and next-output decode. Every output flop is computed one
    // cycle ahead so the register sees its mode in the same cycle the FSM
    // is in the matching state.
    always_comb begin
        state_d     = state_q;
        shift_op_d  = shift_op_q;
        left_d      = left_q;
        count_d     = count_q;
        fill_d      = fill_q;
        usr_s_d     = usr_s_q;
        usr_p_in_d  = usr_p_in_q;
        msb_d       = msb_q;
        lsb_d       = lsb_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
`ifdef USR_SEQ_ROTATE_EN
        rot_d       = rot_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = LOAD;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    usr_s_d     = MODE_LOAD;
                    usr_p_in_d  = cmd_data;
                    count_d     = cmd_count;
                    fill_d      = cmd_fill;
                    shift_op_d  = 1'b0;
                    left_d      = 1'b0;
`ifdef USR_SEQ_ROTATE_EN
                    rot_d       = 1'b0;
`endif
                    case (cmd_op)
                        3'b001: shift_op_d = 1'b1;
                        3'b010: begin
                            shift_op_d = 1'b1;
                            left_d     = 1'b1;
                        end
                        3'b011: begin
                            shift_op_d = 1'b1;
`ifdef USR_SEQ_ROTATE_EN
                            rot_d      = 1'b1;
`endif
                        end
                        3'b100: begin
                            shift_op_d = 1'b1;
                            left_d     = 1'b1;
`ifdef USR_SEQ_ROTATE_EN
                            rot_d      = 1'b1;
`endif
                        end
                        default: shift_op_d = 1'b0;
                    endcase
                end
            end

            LOAD: begin
                usr_p_in_d = '0;
                if (shift_op_q && (count_q != '0)) begin
                    state_d = SHIFT;
                    usr_s_d = left_q ? MODE_SHL : MODE_SHR;
                    // Rotates take their serial bit live from usr_q, so the
                    // registered fill stays 0 for them.
`ifdef USR_SEQ_ROTATE_EN
                    if (!rot_q) begin
                        if (left_q) lsb_d = fill_q;
                        else        msb_d = fill_q;
                    end
`else
                    if (left_q) lsb_d = fill_q;
                    else        msb_d = fill_q;
`endif
                end else begin
                    state_d     = DONE;
                    usr_s_d     = MODE_HOLD;
                    rsp_valid_d = 1'b1;
                end
            end

            SHIFT: begin
                count_d = count_q - CW'(1);
                // A count of 1 here means this edge performs the last step.
                if (count_q == CW'(1)) begin
                    state_d     = DONE;
                    usr_s_d     = MODE_HOLD;
                    msb_d       = 1'b0;
                    lsb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end

            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                usr_s_d     = MODE_HOLD;
                msb_d       = 1'b0;
                lsb_d       = 1'b0;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            shift_op_q  <= 1'b0;
            left_q      <= 1'b0;
            count_q     <= '0;
            fill_q      <= 1'b0;
            usr_s_q     <= MODE_HOLD;
            usr_p_in_q  <= '0;
            msb_q       <= 1'b0;
            lsb_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef USR_SEQ_ROTATE_EN
            rot_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_op_q  <= shift_op_d;
            left_q      <= left_d;
            count_q     <= count_d;
            fill_q      <= fill_d;
            usr_s_q     <= usr_s_d;
            usr_p_in_q  <= usr_p_in_d;
            msb_q       <= msb_d;
            lsb_q       <= lsb_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef USR_SEQ_ROTATE_EN
            rot_q       <= rot_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign usr_s     = usr_s_q;
    assign usr_p_in  = usr_p_in_q;

    // The register holds in DONE, so its output is the settled result word.
    assign rsp_data  = rsp_valid_q ? usr_q : '0;

`ifdef USR_SEQ_ROTATE_EN
    // Rotation feeds the bit about to fall off one end back into the other.
    assign rot_active = (state_q == SHIFT) && rot_q;
    assign usr_msb_in = (rot_active && !left_q) ? usr_q[0]       : msb_q;
    assign usr_lsb_in = (rot_active &&  left_q) ? usr_q[WIDTH-1] : lsb_q;
`else
    assign usr_msb_in = msb_q;
    assign usr_lsb_in = lsb_q;
`endif

endmodule

// File: tb/tb_usr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usr_sequencer
//
// Directed bench for usr_sequencer driving a behavioural 4-bit universal
// shift register. Each scenario task drives a command and compares outputs
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_usr_sequencer;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             clear = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'b000;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [CW-1:0]    cmd_count = '0;
    logic             cmd_fill = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic [1:0]       usr_s;
    logic [WIDTH-1:0] usr_p_in;
    logic             usr_msb_in;
    logic             usr_lsb_in;
    logic [WIDTH-1:0] reg_q = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usr_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk        (clk),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .cmd_fill   (cmd_fill),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .usr_s      (usr_s),
        .usr_p_in   (usr_p_in),
        .usr_msb_in (usr_msb_in),
        .usr_lsb_in (usr_lsb_in),
        .usr_q      (reg_q)
    );

    // Behavioural Universal_Shift_Register.
    always_ff @(posedge clk) begin
        case (usr_s)
            2'b01:   reg_q <= {usr_msb_in, reg_q[WIDTH-1:1]};
            2'b10:   reg_q <= {reg_q[WIDTH-2:0], usr_lsb_in};
            2'b11:   reg_q <= usr_p_in;
            default: reg_q <= reg_q;
        endcase
    end

    // Offer a command and return #1 after the accepting edge.
    task automatic send_cmd(input logic [2:0] op, input logic [3:0] data,
                            input logic [2:0] count, input logic fill);
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Count edges until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
            if (rsp_valid) break;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #12;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (usr_s !== 2'b00) begin bad++; $display("FAIL reset_usr_s got=%b want=00", usr_s); end
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        // 3-step shift right, then abort in the middle of SHIFT.
        send_cmd(3'b001, 4'b1010, 3'd3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        clear = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_data !== 4'b0000) begin bad++; $display("FAIL abort_rsp_data got=%b want=0000", rsp_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (usr_s !== 2'b00) begin bad++; $display("FAIL abort_usr_s got=%b want=00", usr_s); end
        total++; if (usr_p_in !== 4'b0000) begin bad++; $display("FAIL abort_usr_p_in got=%b want=0000", usr_p_in); end
        total++; if (usr_msb_in !== 1'b0) begin bad++; $display("FAIL abort_msb_in got=%b want=0", usr_msb_in); end
        total++; if (usr_lsb_in !== 1'b0) begin bad++; $display("FAIL abort_lsb_in got=%b want=0", usr_lsb_in); end
        @(negedge clk);
        clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL post_abort_idle cycle=%0d rsp_valid=%b cmd_ready=%b want 0/1", i, rsp_valid, cmd_ready); end
        end
    endtask

    task automatic test_load();
        int edges;
        send_cmd(3'b000, 4'b1010, 3'd3, 1'b1);
        total++; if (usr_s !== 2'b11) begin bad++; $display("FAIL load_usr_s got=%b want=11", usr_s); end
        total++; if (usr_p_in !== 4'b1010) begin bad++; $display("FAIL load_p_in got=%b want=1010", usr_p_in); end
        total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL load_flags cmd_ready=%b busy=%b want 0/1", cmd_ready, busy); end
        wait_rsp(edges);
        total++; if (edges !== 1) begin bad++; $display("FAIL load_latency got=%0d want=1", edges); end
        total++; if (rsp_data !== 4'b1010) begin bad++; $display("FAIL load_rsp_data got=%b want=1010", rsp_data); end
        handshake();
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 4'b0000 || cmd_ready !== 1'b1) begin bad++; $display("FAIL load_release rsp_valid=%b rsp_data=%b cmd_ready=%b want 0/0000/1", rsp_valid, rsp_data, cmd_ready); end
    endtask

    task automatic test_shift_right();
        int edges;
        send_cmd(3'b001, 4'b1010, 3'd2, 1'b1);
        @(posedge clk);
        #1;
        total++; if (usr_s !== 2'b01) begin bad++; $display("FAIL shr_usr_s got=%b want=01", usr_s); end
        total++; if (usr_msb_in !== 1'b1 || usr_lsb_in !== 1'b0) begin bad++; $display("FAIL shr_serial msb=%b lsb=%b want 1/0", usr_msb_in, usr_lsb_in); end
        wait_rsp(edges);
        total++; if (edges + 1 !== 3) begin bad++; $display("FAIL shr_latency got=%0d want=3", edges + 1); end
        total++; if (rsp_data !== 4'b1110) begin bad++; $display("FAIL shr_rsp_data got=%b want=1110", rsp_data); end
        handshake();
    endtask

    task automatic test_shift_left();
        int edges;
        send_cmd(3'b010, 4'b1010, 3'd1, 1'b0);
        @(posedge clk);
        #1;
        total++; if (usr_s !== 2'b10) begin bad++; $display("FAIL shl_usr_s got=%b want=10", usr_s); end
        wait_rsp(edges);
        total++; if (edges + 1 !== 2) begin bad++; $display("FAIL shl_latency got=%0d want=2", edges + 1); end
        total++; if (rsp_data !== 4'b0100) begin bad++; $display("FAIL shl_rsp_data got=%b want=0100", rsp_data); end
        handshake();
    endtask

    task automatic test_rotate();
        int edges;
        logic [3:0] exp_rr;
        logic [3:0] exp_rl;
`ifdef USR_SEQ_ROTATE_EN
        exp_rr = 4'b1101;
        exp_rl = 4'b0111;
`else
        exp_rr = 4'b0101;
        exp_rl = 4'b0110;
`endif
        send_cmd(3'b011, 4'b1011, 3'd1, 1'b0);
        wait_rsp(edges);
        total++; if (rsp_data !== exp_rr) begin bad++; $display("FAIL ror_rsp_data got=%b want=%b", rsp_data, exp_rr); end
        handshake();
        send_cmd(3'b100, 4'b1011, 3'd1, 1'b0);
        wait_rsp(edges);
        total++; if (rsp_data !== exp_rl) begin bad++; $display("FAIL rol_rsp_data got=%b want=%b", rsp_data, exp_rl); end
        handshake();
    endtask

    task automatic test_long_count();
        int edges;
        // Count 5 exceeds WIDTH and must run every step.
        send_cmd(3'b010, 4'b0000, 3'd5, 1'b1);
        wait_rsp(edges);
        total++; if (edges !== 6) begin bad++; $display("FAIL long_latency got=%0d want=6", edges); end
        total++; if (rsp_data !== 4'b1111) begin bad++; $display("FAIL long_rsp_data got=%b want=1111", rsp_data); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int edges;
        send_cmd(3'b001, 4'b0110, 3'd0, 1'b1);
        wait_rsp(edges);
        total++; if (edges !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", edges); end
        total++; if (rsp_data !== 4'b0110) begin bad++; $display("FAIL zero_rsp_data got=%b want=0110", rsp_data); end
        // Second command is offered and held while the response is stalled.
        cmd_op    = 3'b000;
        cmd_data  = 4'b0011;
        cmd_count = 3'd0;
        cmd_fill  = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++; if (rsp_valid !== 1'b1 || rsp_data !== 4'b0110 || cmd_ready !== 1'b0) begin bad++; $display("FAIL stall cycle=%0d rsp_valid=%b rsp_data=%b cmd_ready=%b want 1/0110/0", i, rsp_valid, rsp_data, cmd_ready); end
        end
        handshake();
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_release rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready); end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        total++; if (usr_s !== 2'b11 || usr_p_in !== 4'b0011 || cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept usr_s=%b p_in=%b cmd_ready=%b want 11/0011/0", usr_s, usr_p_in, cmd_ready); end
        wait_rsp(edges);
        total++; if (edges !== 1 || rsp_data !== 4'b0011) begin bad++; $display("FAIL b2b_second edges=%0d rsp_data=%b want 1/0011", edges, rsp_data); end
        handshake();
    endtask

    initial begin
        $display("[TB] usr_sequencer directed run");
        test_reset();
        test_load();
        test_shift_right();
        test_shift_left();
        test_rotate();
        test_long_count();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
